// File: rtl/fifo_burst_reader_pkg.sv
// rtl/fifo_burst_reader_pkg.sv - shared state encodings and constants for the FIFO burst reader
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int BURST_CNT_W = 16;

endpackage

// File: rtl/fifo_burst_out_reg.sv
// rtl/fifo_burst_out_reg.sv - registered valid/ready output stage with load/hold control
module fifo_burst_out_reg #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         can_load_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign can_load_o = ~valid_q | ready_i;
    assign valid_o    = valid_q;
    assign data_o     = data_q;

    // The MSB of the payload is the last flag; it drops with valid so it never lingers.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d       = 1'b0;
            data_d[W-1]   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - groups show-ahead FIFO words into bursts on a valid/ready stream
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int AW        = 3,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 15,
    parameter int TW        = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [AW:0]            fifo_num_val_i,
    input  logic [DW-1:0]          fifo_dout_i,
    output logic                   fifo_rd_o,
    input  logic                   flush_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [DW-1:0]          m_data_o,
    output logic                   m_last_o,
    output logic [AW:0]            m_len_o,
    output logic                   busy_o,
    output logic [BURST_CNT_W-1:0] burst_cnt_o
);

    localparam logic [AW:0] BURST_LEN_C = (AW+1)'(BURST_LEN);
    localparam logic [AW:0] REM_ONE     = (AW+1)'(1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [AW:0]            rem_q, rem_d;
    logic [AW:0]            len_q, len_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic          load;
    logic          can_load;
    logic [DW:0]   out_payload;

    fifo_burst_out_reg #(
        .W (DW + 1)
    ) u_out_reg (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (load),
        .data_i     ({(rem_q == REM_ONE), fifo_dout_i}),
        .ready_i    (m_ready_i),
        .can_load_o (can_load),
        .valid_o    (m_valid_o),
        .data_o     (out_payload)
    );

    assign m_last_o    = out_payload[DW];
    assign m_data_o    = out_payload[DW-1:0];
    assign m_len_o     = len_q;
    assign burst_cnt_o = burst_cnt_q;
    assign busy_o      = (state_q != ST_IDLE) | m_valid_o;
    // Pops depend only on FSM state and the output handshake, never on the FIFO count.
    assign fifo_rd_o   = load;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rem_d       = rem_q;
        len_d       = len_q;
        burst_cnt_d = burst_cnt_q;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_num_val_i == '0) begin
                    timer_d = '0;
                end else if (timer_q != TIMEOUT_C) begin
                    timer_d = timer_q + TW'(1);
                end
                if (fifo_num_val_i >= BURST_LEN_C) begin
                    state_d = ST_BURST;
                    len_d   = BURST_LEN_C;
                    rem_d   = BURST_LEN_C;
                    timer_d = '0;
                end else if ((fifo_num_val_i != '0) && ((timer_q == TIMEOUT_C) || flush_i)) begin
                    state_d = ST_BURST;
                    len_d   = fifo_num_val_i;
                    rem_d   = fifo_num_val_i;
                    timer_d = '0;
                end
            end
            ST_BURST: begin
                load = can_load && (rem_q != '0);
                if (load) begin
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (m_valid_o && m_ready_i && m_last_o) begin
                    burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            rem_q       <= '0;
            len_q       <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rem_q       <= rem_d;
            len_q       <= len_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

    localparam int AW        = 3;
    localparam int DW        = 8;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 15;
    localparam int TW        = 4;
    localparam int DEPTH     = 1 << AW;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [AW:0]   fifo_num_val_i;
    logic [DW-1:0] fifo_dout_i;
    logic          fifo_rd_o;
    logic          flush_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic [AW:0]   m_len_o;
    logic          busy_o;
    logic [15:0]   burst_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] push_q[$];

    logic          s_rd, s_valid, s_ready, s_last, s_busy;
    logic [DW-1:0] s_data;
    logic [AW:0]   s_len, s_num;
    logic [15:0]   s_cnt;
    int            pop_empty = 0;

    fifo_burst_reader #(
        .AW(AW), .DW(DW), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT), .TW(TW)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .fifo_num_val_i (fifo_num_val_i),
        .fifo_dout_i    (fifo_dout_i),
        .fifo_rd_o      (fifo_rd_o),
        .flush_i        (flush_i),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_data_o       (m_data_o),
        .m_last_o       (m_last_o),
        .m_len_o        (m_len_o),
        .busy_o         (busy_o),
        .burst_cnt_o    (burst_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_num_val_i = (AW+1)'(fifo_q.size());
        fifo_dout_i    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    // Called just after a falling edge: snapshot outputs, then advance the FIFO model over the rising edge.
    task automatic tick();
        #4;
        s_rd = fifo_rd_o; s_valid = m_valid_o; s_ready = m_ready_i; s_last = m_last_o;
        s_busy = busy_o; s_data = m_data_o; s_len = m_len_o; s_num = fifo_num_val_i;
        s_cnt = burst_cnt_o;
        if (s_rd && s_num == 0) pop_empty++;
        @(posedge clk_i);
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (push_q.size() > 0 && fifo_q.size() < DEPTH) fifo_q.push_back(push_q.pop_front());
        #1 drive_fifo();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i = 1'b1; flush_i = 1'b0; m_ready_i = 1'b0;
        fifo_q.delete(); push_q.delete(); drive_fifo();
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 32'(m_valid_o), 0);
        check("rst_rd", 32'(fifo_rd_o), 0);
        check("rst_cnt", 32'(burst_cnt_o), 0);
        check("rst_len", 32'(m_len_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        reset_i = 1'b0;
    endtask

    typedef struct {
        int n;
        int flush_at;
        int exp_len;
        int exp_pop;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first, idx, cyc, pcnt;
        int hold_viol, stall_pop, data_err, last_err, gap_cnt;
        logic between, pv, pr, pl;
        logic [DW-1:0] pd;

        tbl[0] = '{n: 4, flush_at: -1, exp_len: 4, exp_pop: 1};
        tbl[1] = '{n: 2, flush_at: -1, exp_len: 2, exp_pop: 16};
        tbl[2] = '{n: 3, flush_at: 2,  exp_len: 3, exp_pop: 3};
        tbl[3] = '{n: 8, flush_at: -1, exp_len: 4, exp_pop: 1};
        tbl[4] = '{n: 1, flush_at: 0,  exp_len: 1, exp_pop: 1};
        tbl[5] = '{n: 1, flush_at: -1, exp_len: 1, exp_pop: 16};

        @(negedge clk_i);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int k = 0; k < tbl[v].n; k++) fifo_q.push_back(DW'((v << 4) | k));
            drive_fifo();
            m_ready_i = 1'b1;
            first = -1; cyc = 0;
            while (first < 0 && cyc < 40) begin
                flush_i = (cyc == tbl[v].flush_at);
                tick();
                if (s_rd) first = cyc;
                cyc++;
            end
            flush_i = 1'b0;
            check($sformatf("v%0d_first_pop", v), 32'(first), 32'(tbl[v].exp_pop));
            check($sformatf("v%0d_len", v), 32'(s_len), 32'(tbl[v].exp_len));
            idx = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (s_valid && s_ready) begin
                    check($sformatf("v%0d_data%0d", v, idx), 32'(s_data), 32'((v << 4) | idx));
                    check($sformatf("v%0d_last%0d", v, idx), 32'(s_last), 32'(idx == tbl[v].exp_len - 1));
                    idx++;
                    if (s_last) break;
                end
            end
            check($sformatf("v%0d_words", v), 32'(idx), 32'(tbl[v].exp_len));
            tick();
            check($sformatf("v%0d_burst_cnt", v), 32'(s_cnt), 1);
        end

        // Eight words with alternating ready: two full bursts, stalls hold the output.
        do_reset();
        for (int k = 0; k < 8; k++) fifo_q.push_back(DW'(8'hB0 + k));
        drive_fifo();
        idx = 0; hold_viol = 0; stall_pop = 0; data_err = 0; last_err = 0; gap_cnt = 0;
        between = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        for (int c = 0; c < 80 && idx < 8; c++) begin
            m_ready_i = (c % 2 == 0);
            tick();
            if (pv && !pr && (!s_valid || s_data !== pd || s_last !== pl)) hold_viol++;
            if (s_rd && s_valid && !s_ready) stall_pop++;
            if (between) begin
                if (!s_busy) gap_cnt++;
                if (s_rd) between = 1'b0;
            end
            if (s_valid && s_ready) begin
                if (s_data !== DW'(8'hB0 + idx)) data_err++;
                if (s_last !== (idx % 4 == 3)) last_err++;
                if (s_last && idx == 3) between = 1'b1;
                idx++;
            end
            pv = s_valid; pr = s_ready; pd = s_data; pl = s_last;
        end
        m_ready_i = 1'b1;
        tick();
        check("bp_words", 32'(idx), 8);
        check("bp_hold_viol", 32'(hold_viol), 0);
        check("bp_stall_pop", 32'(stall_pop), 0);
        check("bp_data_err", 32'(data_err), 0);
        check("bp_last_err", 32'(last_err), 0);
        check("bp_idle_gap", 32'(gap_cnt >= 1), 1);
        check("bp_burst_cnt", 32'(s_cnt), 2);

        // Reset in the middle of a burst after two words.
        do_reset();
        for (int k = 0; k < 4; k++) fifo_q.push_back(DW'(8'hC0 + k));
        drive_fifo();
        m_ready_i = 1'b1;
        idx = 0;
        for (int c = 0; c < 20 && idx < 2; c++) begin
            tick();
            if (s_valid && s_ready) idx++;
        end
        check("mr_accepted", 32'(idx), 2);
        check("mr_pre_valid", 32'(m_valid_o), 1);
        reset_i = 1'b1;
        #1;
        check("mr_valid", 32'(m_valid_o), 0);
        check("mr_rd", 32'(fifo_rd_o), 0);
        check("mr_cnt", 32'(burst_cnt_o), 0);
        check("mr_busy", 32'(busy_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Random traffic against a word-order scoreboard and burst-level rules.
        begin
            logic [DW-1:0] exp_q[$];
            int seq, pops, sum_len, cur_len, widx, bursts, len_err, idle_run, full_run;
            int timeout_err, full_err, drained;
            do_reset();
            seq = 0; pops = 0; sum_len = 0; cur_len = 0; widx = 0; bursts = 0;
            len_err = 0; idle_run = 0; full_run = 0; timeout_err = 0; full_err = 0;
            data_err = 0; last_err = 0; pop_empty = 0;
            for (int c = 0; c < 8000; c++) begin
                m_ready_i = ($urandom_range(0, 3) != 0);
                flush_i   = ($urandom_range(0, 40) == 0);
                if (fifo_q.size() + push_q.size() < DEPTH && $urandom_range(0, 2) == 0) begin
                    push_q.push_back(DW'(seq));
                    exp_q.push_back(DW'(seq));
                    seq++;
                end
                tick();
                if (s_rd) pops++;
                if (s_valid && s_ready) begin
                    if (widx == 0) begin
                        cur_len = int'(s_len);
                        sum_len += cur_len;
                        if (cur_len < 1 || cur_len > BURST_LEN) len_err++;
                    end else if (int'(s_len) != cur_len) begin
                        len_err++;
                    end
                    if (exp_q.size() == 0 || s_data !== exp_q.pop_front()) data_err++;
                    widx++;
                    if (s_last !== (widx == cur_len)) last_err++;
                    if (s_last) begin
                        bursts++;
                        widx = 0;
                    end
                end
                idle_run = (!s_busy && s_num > 0) ? idle_run + 1 : 0;
                full_run = (!s_busy && s_num >= BURST_LEN) ? full_run + 1 : 0;
                if (idle_run > TIMEOUT + 1) timeout_err++;
                if (full_run > 1) full_err++;
            end
            flush_i = 1'b0;
            m_ready_i = 1'b1;
            drained = 0;
            for (int c = 0; c < 200; c++) begin
                tick();
                if (s_rd) pops++;
                if (s_valid && s_ready) begin
                    if (widx == 0) begin
                        cur_len = int'(s_len);
                        sum_len += cur_len;
                    end
                    if (exp_q.size() == 0 || s_data !== exp_q.pop_front()) data_err++;
                    widx++;
                    if (s_last !== (widx == cur_len)) last_err++;
                    if (s_last) begin
                        bursts++;
                        widx = 0;
                    end
                end
                if (fifo_q.size() == 0 && push_q.size() == 0 && !busy_o) begin
                    drained = 1;
                    break;
                end
            end
            pcnt = bursts;
            check("rnd_drained", 32'(drained), 1);
            check("rnd_data_err", 32'(data_err), 0);
            check("rnd_last_err", 32'(last_err), 0);
            check("rnd_len_err", 32'(len_err), 0);
            check("rnd_sum_len_vs_pops", 32'(sum_len), 32'(pops));
            check("rnd_pops_vs_pushed", 32'(pops), 32'(seq));
            check("rnd_left_in_scoreboard", 32'(exp_q.size()), 0);
            check("rnd_pop_empty", 32'(pop_empty), 0);
            check("rnd_timeout_err", 32'(timeout_err), 0);
            check("rnd_full_wait_err", 32'(full_err), 0);
            check("rnd_burst_cnt", 32'(burst_cnt_o), 32'(pcnt % 65536));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
